// File: rtl/lcd_bus_if.sv
// lcd_bus_if: HD44780-style parallel LCD bus shared by the controller and its snoopers
interface lcd_bus_if;
   logic       disp_rs;
   logic       disp_rw;
   logic       disp_en;
   logic [7:0] disp_data;
   modport master (output disp_rs, disp_rw, disp_en, disp_data);
   modport slave  (input  disp_rs, disp_rw, disp_en, disp_data);
endinterface

// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: snoops the LCD bus and mirrors screen text, cursor, busy and mode state
module lcd_bus_monitor #(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input  logic         disp_clk,
   input  logic         disp_async_rst,
   lcd_bus_if.slave     bus_i,
   output logic [255:0] screen_o,
   output logic [6:0]   cursor_addr_o,
   output logic         busy_o,
   output logic [7:0]   status_out_o,
   output logic         char_strobe_o,
   output logic [7:0]   char_code_o,
   output logic         frame_done_o,
   output logic         display_enabled_o,
   output logic         proto_err_o
);
   logic [10:0] sync1_q, sync2_q;
   logic        en_prev_q, fall_q;
   logic [9:0]  hold_q;
   logic [17:0] cnt_q, cnt_d;
   logic [7:0]  scr_q [32];
   logic [7:0]  scr_d [32];
   logic [6:0]  cur_q, cur_d, cur_step;
   logic        id_q, id_d, den_q, den_d, err_q, err_d;
   logic        strobe_q, strobe_d, frame_q, frame_d;
   logic [7:0]  status_q, status_d, code_q, code_d;
   logic        rs, rw, busy;
   logic [7:0]  data;
   logic [4:0]  pos;

   assign {rs, rw, data} = hold_q;
   assign busy = cnt_q != '0;
   // DDRAM 0x00-0x0F maps to positions 0-15, 0x40-0x4F to 16-31; bits [5:4] must be clear
   assign pos = {cur_q[6], cur_q[3:0]};
   assign cur_step = id_q ? (cur_q == 7'h27 ? 7'h40 : cur_q == 7'h67 ? 7'h00 : cur_q + 7'd1)
                          : (cur_q == 7'h00 ? 7'h67 : cur_q == 7'h40 ? 7'h27 : cur_q - 7'd1);

   for (genvar g = 0; g < 32; g++) begin : g_flat
      assign screen_o[255 - 8*g -: 8] = scr_q[g];
   end
   assign cursor_addr_o     = cur_q;
   assign busy_o            = busy;
   assign status_out_o      = status_q;
   assign char_strobe_o     = strobe_q;
   assign char_code_o       = code_q;
   assign frame_done_o      = frame_q;
   assign display_enabled_o = den_q;
   assign proto_err_o       = err_q;

   // Synchronize the bus, hold the last enabled-phase values and flag the en falling edge
   always_ff @(posedge disp_clk or negedge disp_async_rst) begin
      if (!disp_async_rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         en_prev_q <= 1'b0;
         fall_q    <= 1'b0;
         hold_q    <= '0;
      end else begin
         sync1_q   <= {bus_i.disp_en, bus_i.disp_rs, bus_i.disp_rw, bus_i.disp_data};
         sync2_q   <= sync1_q;
         en_prev_q <= sync2_q[10];
         fall_q    <= en_prev_q & ~sync2_q[10];
         if (sync2_q[10]) hold_q <= sync2_q[9:0];
      end
   end

   // Decode the held transfer; commands are classified by their highest set bit
   always_comb begin
      scr_d    = scr_q;
      cur_d    = cur_q;
      id_d     = id_q;
      den_d    = den_q;
      err_d    = err_q;
      status_d = status_q;
      code_d   = code_q;
      strobe_d = 1'b0;
      frame_d  = 1'b0;
      cnt_d    = busy ? cnt_q - 18'd1 : cnt_q;
      if (fall_q && rw) begin
         err_d    = err_q | rs;
         status_d = rs ? status_q : {busy, cur_q};
      end else if (fall_q) begin
         err_d = err_q | busy;
         cnt_d = 18'(BUSY_CYCLES);
         if (rs) begin
            code_d   = data;
            strobe_d = 1'b1;
            frame_d  = cur_q == 7'h4F;
            cur_d    = cur_step;
            if (cur_q[5:4] == 2'b00) scr_d[pos] = data;
         end else if (data[7]) begin
            cur_d = data[6:0];
         end else if (data[6:5] == 2'b01) begin
            err_d = err_q | busy | ~data[4];
         end else if (data[6:3] == 4'b0001) begin
            den_d = data[2];
         end else if (data[6:2] == 5'b00001) begin
            id_d  = data[1];
            err_d = err_q | busy | data[0];
         end else if (data[6:1] == 6'b000001) begin
            cur_d = '0;
            cnt_d = 18'(CLEAR_CYCLES);
         end else if (data[6:0] == 7'h01) begin
            for (int i = 0; i < 32; i++) scr_d[i] = 8'h20;
            cur_d = '0;
            id_d  = 1'b1;
            cnt_d = 18'(CLEAR_CYCLES);
         end
      end
   end

   // Shadow display state registers
   always_ff @(posedge disp_clk or negedge disp_async_rst) begin
      if (!disp_async_rst) begin
         for (int i = 0; i < 32; i++) scr_q[i] <= 8'h20;
         cur_q    <= '0;
         id_q     <= 1'b1;
         den_q    <= 1'b0;
         err_q    <= 1'b0;
         status_q <= '0;
         code_q   <= '0;
         strobe_q <= 1'b0;
         frame_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         for (int i = 0; i < 32; i++) scr_q[i] <= scr_d[i];
         cur_q    <= cur_d;
         id_q     <= id_d;
         den_q    <= den_d;
         err_q    <= err_d;
         status_q <= status_d;
         code_q   <= code_d;
         strobe_q <= strobe_d;
         frame_q  <= frame_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule
